bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//   Shares the single memory-mapped bus (read/write/addr/data/ack) between NUM_REQ masters:
//   bootloader on port 0, CPU data port on 1, spare master on 2.
//   Round-robin grant with a boot_lock override so the bootloader owns the bus exclusively
//   while loading. Adds a per-transaction timeout so a silent slave cannot hang the system.
//   Replaces per-master tristate sharing with a registered-grant mux.
// PARAMETERS
//   NUM_REQ  3    number of masters (2..8)
//   ADDR_W   32   bus address width
//   DATA_W   32   bus data width
//   TIMEOUT  255  BUSY cycles without ack_i before abort; 0 = timeout disabled
// PORTS
//   clk      in   1               system clock, all logic on rising edge
//   rst      in   1               asynchronous, active-high reset
//   m_read   in   NUM_REQ         per-master read request
//   m_write  in   NUM_REQ         per-master write request
//   m_addr   in   NUM_REQ*ADDR_W  per-master address, master r at [r*ADDR_W +: ADDR_W]
//   m_wdata  in   NUM_REQ*DATA_W  per-master write data, same packing
//   m_ack    out  NUM_REQ         one-cycle completion pulse to granted master
//   m_err    out  NUM_REQ         one-cycle timeout flag, coincident with m_ack
//   m_rdata  out  DATA_W          read data, = data_i (broadcast; valid with m_ack)
//   boot_lock in  1               1 = only master 0 is eligible for grant
//   grant    out  NUM_REQ         one-hot owner of the bus, 0 when idle
//   busy     out  1               transaction in flight
//   read_o   out  1               bus read strobe
//   write_o  out  1               bus write strobe
//   addr_o   out  ADDR_W          bus address
//   data_o   out  DATA_W          bus write data
//   data_i   in   DATA_W          bus read data
//   ack_i    in   1               bus slave acknowledge
// BEHAVIOUR
//   Reset: grant=0, busy=0, read_o=write_o=0, addr_o=data_o=0, m_ack=m_err=0, timeout cnt=0,
//     rr pointer=NUM_REQ-1 (master 0 wins first). Reset mid-transaction drops the bus immediately.
//   Request: master r requests when m_read[r]|m_write[r]; if both are set, a write is performed.
//   FSM IDLE: bus outputs 0. If any eligible request: winner = first requester scanning
//     ptr+1, ptr+2, ... modulo NUM_REQ. On the next edge register grant, op, addr, wdata
//     from the winner; go to BUSY.
//     boot_lock=1 -> eligible set = {0} only. ack_i in IDLE is ignored.
//   FSM BUSY: drive read_o/write_o/addr_o/data_o from the latched registers (not live inputs).
//     Latency: request at cycle N -> strobe on bus at cycle N+1.
//     ack_i=1: m_ack[g]=ack_i combinationally this cycle; m_rdata=data_i.
//       Next edge: ptr<=g, grant<=0, go to IDLE.
//     Timeout count ++ each BUSY cycle without ack; cnt width $clog2(TIMEOUT+1).
//       When cnt==TIMEOUT-1 with no ack: m_ack[g]=m_err[g]=1 this cycle, release as above.
//       ack_i in the same cycle wins, with m_err=0.
//   Master drops its request while BUSY: transaction still completes and m_ack still pulses.
//   boot_lock changes mid-BUSY: no abort; it takes effect at the next IDLE arbitration.
//   Masters must deassert or present the next request the cycle after m_ack.
//     Minimum of one IDLE cycle between transactions.
//   At most one bit of grant/m_ack/m_err is set at any time.
// TESTING
//   1. m_read[1]=1, addr 0x4000001D; ack_i 3 cycles later with data_i=0x55
//      -> read_o from next cycle, grant=3'b010; m_ack[1] pulse with ack; m_rdata=0x55; then IDLE.
//   2. All masters request continuously, ack_i 1 cycle after each strobe
//      -> grant sequence 001,010,100,001; one IDLE cycle between each.
//   3. boot_lock=1, masters 0 and 1 requesting -> only master 0 granted.
//      Drop boot_lock -> master 1 granted at the next IDLE.
//   4. TIMEOUT=8, master 2 writes, ack_i never asserted -> m_ack[2]=m_err[2]=1 on BUSY cycle 8.
//      Bus released; a pending master 0 is served next.
//   5. rst pulsed mid-BUSY -> write_o/read_o/grant=0 asynchronously.
//      After release, simultaneous requests from 0 and 2 -> master 0 first.
//   6. Master 1 sets m_read and m_write, wdata 0x42 -> write_o=1, data_o=0x42, read_o=0.
//      m_addr changed during BUSY -> addr_o unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Shares one memory-mapped bus between NUM_REQ masters (port 0 =
//            bootloader, 1 = CPU data, 2 = spare). Round-robin arbitration,
//            boot_lock restricts eligibility to master 0, and a per-transaction
//            timeout aborts transfers that a slave never acknowledges.
// Ports    : clk, rst (async, active-high)
//            m_read/m_write/m_addr/m_wdata : packed per-master requests
//            m_ack/m_err/m_rdata           : per-master completion/response
//            boot_lock                     : only master 0 may win arbitration
//            grant/busy                    : registered owner / in-flight flag
//            read_o/write_o/addr_o/data_o  : registered bus-side strobes
//            data_i/ack_i                  : bus-side response
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        m_read,
    input  logic [NUM_REQ-1:0]        m_write,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
    input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
    output logic [NUM_REQ-1:0]        m_ack,
    output logic [NUM_REQ-1:0]        m_err,
    output logic [DATA_W-1:0]         m_rdata,
    input  logic                      boot_lock,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      read_o,
    output logic                      write_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      ack_i
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    // Keep at least one bit so the counter exists when the timeout is disabled.
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_REQ-1:0] c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_gidx;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_any;
    logic [c_PTR_W-1:0]   w_win;
    int                   w_idx;
    logic                 w_timeout;
    logic                 w_done;

    // Round-robin pick: scan downwards so the last hit written is the one
    // closest after r_ptr, i.e. the highest-priority eligible requester.
    always_comb begin
        w_req  = m_read | m_write;
        w_elig = boot_lock ? (w_req & c_ONE) : w_req;
        w_any  = 1'b0;
        w_win  = '0;
        w_idx  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (w_elig[w_idx[c_PTR_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[c_PTR_W-1:0];
            end
        end
    end

    // Timeout fires on the TIMEOUT-th BUSY cycle; a real ack that cycle wins.
    always_comb begin
        w_timeout = (TIMEOUT != 0) && (r_state == S_BUSY) && (r_cnt == c_CNT_LAST);
        w_done    = (r_state == S_BUSY) && (ack_i || w_timeout);
        m_ack     = w_done ? grant : '0;
        m_err     = (w_timeout && !ack_i) ? grant : '0;
        m_rdata   = data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= c_PTR_W'(NUM_REQ - 1);
            r_gidx  <= '0;
            r_cnt   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // ack_i is deliberately ignored here.
                    if (w_any) begin
                        r_state <= S_BUSY;
                        r_gidx  <= w_win;
                        r_cnt   <= '0;
                        grant   <= c_ONE << w_win;
                        busy    <= 1'b1;
                        // Write takes precedence when both strobes are requested.
                        write_o <= m_write[w_win];
                        read_o  <= ~m_write[w_win];
                        addr_o  <= m_addr[w_win*ADDR_W +: ADDR_W];
                        data_o  <= m_wdata[w_win*DATA_W +: DATA_W];
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_ptr   <= r_gidx;
                        grant   <= '0;
                        busy    <= 1'b0;
                        read_o  <= 1'b0;
                        write_o <= 1'b0;
                        addr_o  <= '0;
                        data_o  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
